// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared lamp encodings, fault codes, head ids and FSM states for the conflict monitor.
// Also holds the lamp classifier and the legal-transition table used by every head.
package traffic_conflict_monitor_pkg;

  typedef enum logic [2:0] {
    LAMP_DARK  = 3'd0,
    LAMP_R     = 3'd1,
    LAMP_Y     = 3'd2,
    LAMP_G     = 3'd3,
    LAMP_MULTI = 3'd4
  } lamp_e;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_MULTI    = 3'd2;
  localparam logic [2:0] CODE_SEQ      = 3'd3;
  localparam logic [2:0] CODE_SHORT_G  = 3'd4;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd5;
  localparam logic [2:0] CODE_DARK     = 3'd6;

  localparam logic [1:0] HEAD_A = 2'd0;
  localparam logic [1:0] HEAD_B = 2'd1;
  localparam logic [1:0] HEAD_W = 2'd2;

  function automatic lamp_e encode_lamp(input logic g, input logic y, input logic r);
    case ({g, y, r})
      3'b000:  return LAMP_DARK;
      3'b001:  return LAMP_R;
      3'b010:  return LAMP_Y;
      3'b100:  return LAMP_G;
      default: return LAMP_MULTI;
    endcase
  endfunction

  // Only the normal vehicle cycle and the flash-dark excursion from red are legal.
  function automatic logic legal_step(input lamp_e from, input lamp_e to);
    return (from == LAMP_R    && to == LAMP_G)    ||
           (from == LAMP_G    && to == LAMP_Y)    ||
           (from == LAMP_Y    && to == LAMP_R)    ||
           (from == LAMP_R    && to == LAMP_DARK) ||
           (from == LAMP_DARK && to == LAMP_R);
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_head_tracker.sv
// Tracks one vehicle head: lamp encoding, dwell counter and per-head violation flags.
// Flags describe the sample currently on G/Y/R against the remembered history.
module traffic_conflict_monitor_head_tracker
  import traffic_conflict_monitor_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DARK   = 4,
  parameter int CNT_W      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             G,
  input  logic             Y,
  input  logic             R,
  input  logic             en,
  output logic [2:0]       enc,
  output logic [CNT_W-1:0] dwell,
  output logic             multi,
  output logic             bad_seq,
  output logic             short_g,
  output logic             short_y,
  output logic             dark_to
);

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;

  lamp_e            cur;
  lamp_e            prev;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwell_nxt;
  logic             changed;

  always_comb begin
    cur       = encode_lamp(G, Y, R);
    changed   = (cur != prev);
    dwell_nxt = dwell_q;
    if (changed) begin
      dwell_nxt = CNT_W'(1);
    end else if (dwell_q != DWELL_MAX) begin
      dwell_nxt = dwell_q + CNT_W'(1);
    end
  end

  // Leaving-state checks use the dwell of the state being left; dark uses the running dwell.
  assign multi   = (cur == LAMP_MULTI);
  assign bad_seq = en && changed && !legal_step(prev, cur);
  assign short_g = en && changed && (prev == LAMP_G) && (dwell_q < CNT_W'(MIN_GREEN));
  assign short_y = en && changed && (prev == LAMP_Y) && (dwell_q < CNT_W'(MIN_YELLOW));
  assign dark_to = en && (cur == LAMP_DARK) && (dwell_nxt > CNT_W'(MAX_DARK));
  assign enc     = cur;
  assign dwell   = dwell_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev    <= LAMP_DARK;
      dwell_q <= '0;
    end else begin
      prev    <= cur;
      dwell_q <= dwell_nxt;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-output watchdog: registers the eight lamp lines, checks them, and latches
// the first fault (code + head) until CLR, raising FLASH_REQ while faulted.
module traffic_conflict_monitor
  import traffic_conflict_monitor_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DARK   = 4,
  parameter int CNT_W      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Ga,
  input  logic             Ya,
  input  logic             Ra,
  input  logic             Gb,
  input  logic             Yb,
  input  logic             Rb,
  input  logic             Gw,
  input  logic             Rw,
  input  logic             CLR,
  output logic             FAULT,
  output logic [2:0]       FAULT_CODE,
  output logic [1:0]       FAULT_HEAD,
  output logic             FLASH_REQ,
  output logic             ARMED,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_dwell_a,
  output logic [CNT_W-1:0] dbg_dwell_b
);

  logic [7:0] lamp_q;
  logic       ga_q, ya_q, ra_q, gb_q, yb_q, rb_q, gw_q, rw_q;
  state_e     state, state_nxt;
  logic [2:0] code_q, code_nxt, viol_code;
  logic [1:0] head_q, head_nxt, viol_head;
  logic       seq_en;
  logic [2:0] enc_a, enc_b;
  logic       multi_a, bad_a, sg_a, sy_a, dark_a;
  logic       multi_b, bad_b, sg_b, sy_b, dark_b;
  logic       go_a, go_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lamp_q <= '0;
    else        lamp_q <= {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw};
  end

  assign {ga_q, ya_q, ra_q, gb_q, yb_q, rb_q, gw_q, rw_q} = lamp_q;
  assign seq_en = (state == ST_MONITOR);

  traffic_conflict_monitor_head_tracker #(
    .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK), .CNT_W(CNT_W)
  ) u_head_a (
    .CLK(CLK), .RST_N(RST_N), .G(ga_q), .Y(ya_q), .R(ra_q), .en(seq_en),
    .enc(enc_a), .dwell(dbg_dwell_a), .multi(multi_a), .bad_seq(bad_a),
    .short_g(sg_a), .short_y(sy_a), .dark_to(dark_a)
  );

  traffic_conflict_monitor_head_tracker #(
    .MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .MAX_DARK(MAX_DARK), .CNT_W(CNT_W)
  ) u_head_b (
    .CLK(CLK), .RST_N(RST_N), .G(gb_q), .Y(yb_q), .R(rb_q), .en(seq_en),
    .enc(enc_b), .dwell(dbg_dwell_b), .multi(multi_b), .bad_seq(bad_b),
    .short_g(sg_b), .short_y(sy_b), .dark_to(dark_b)
  );

  assign go_a = ga_q | ya_q;
  assign go_b = gb_q | yb_q;

  // Lowest code wins; within a code A beats B beats W.
  always_comb begin
    viol_code = CODE_NONE;
    viol_head = HEAD_A;
    if      (go_a && (go_b || gw_q)) begin viol_code = CODE_CONFLICT; viol_head = HEAD_A; end
    else if (go_b && gw_q)           begin viol_code = CODE_CONFLICT; viol_head = HEAD_B; end
    else if (multi_a)                begin viol_code = CODE_MULTI;    viol_head = HEAD_A; end
    else if (multi_b)                begin viol_code = CODE_MULTI;    viol_head = HEAD_B; end
    else if (gw_q && rw_q)           begin viol_code = CODE_MULTI;    viol_head = HEAD_W; end
    else if (bad_a)                  begin viol_code = CODE_SEQ;      viol_head = HEAD_A; end
    else if (bad_b)                  begin viol_code = CODE_SEQ;      viol_head = HEAD_B; end
    else if (sg_a)                   begin viol_code = CODE_SHORT_G;  viol_head = HEAD_A; end
    else if (sg_b)                   begin viol_code = CODE_SHORT_G;  viol_head = HEAD_B; end
    else if (sy_a)                   begin viol_code = CODE_SHORT_Y;  viol_head = HEAD_A; end
    else if (sy_b)                   begin viol_code = CODE_SHORT_Y;  viol_head = HEAD_B; end
    else if (dark_a)                 begin viol_code = CODE_DARK;     viol_head = HEAD_A; end
    else if (dark_b)                 begin viol_code = CODE_DARK;     viol_head = HEAD_B; end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code_q;
    head_nxt  = head_q;
    case (state)
      ST_ARM: begin
        if (viol_code != CODE_NONE) begin
          state_nxt = ST_FAULT;
          code_nxt  = viol_code;
          head_nxt  = viol_head;
        end else if (enc_a == LAMP_R && enc_b == LAMP_R && rw_q) begin
          state_nxt = ST_MONITOR;
        end
      end
      ST_MONITOR: begin
        if (viol_code != CODE_NONE) begin
          state_nxt = ST_FAULT;
          code_nxt  = viol_code;
          head_nxt  = viol_head;
        end
      end
      ST_FAULT: begin
        if (CLR) begin
          state_nxt = ST_ARM;
          code_nxt  = CODE_NONE;
          head_nxt  = HEAD_A;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_ARM;
      code_q <= CODE_NONE;
      head_q <= HEAD_A;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      head_q <= head_nxt;
    end
  end

  assign FAULT      = (state == ST_FAULT);
  assign FLASH_REQ  = FAULT;
  assign ARMED      = (state == ST_MONITOR);
  assign FAULT_CODE = code_q;
  assign FAULT_HEAD = head_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: vector table, corner-case sequences and a
// mutated legal controller cycle checked against a rule-level reference model.
module tb_traffic_conflict_monitor;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] lamps;   // {Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw}
  logic       clr;
  logic       fault, flash_req, armed;
  logic [2:0] fault_code;
  logic [1:0] fault_head, dbg_state;
  logic [3:0] dbg_dwell_a, dbg_dwell_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  traffic_conflict_monitor dut (
    .CLK(CLK), .RST_N(RST_N),
    .Ga(lamps[7]), .Ya(lamps[6]), .Ra(lamps[5]),
    .Gb(lamps[4]), .Yb(lamps[3]), .Rb(lamps[2]),
    .Gw(lamps[1]), .Rw(lamps[0]),
    .CLR(clr),
    .FAULT(fault), .FAULT_CODE(fault_code), .FAULT_HEAD(fault_head),
    .FLASH_REQ(flash_req), .ARMED(armed),
    .dbg_state(dbg_state), .dbg_dwell_a(dbg_dwell_a), .dbg_dwell_b(dbg_dwell_b)
  );

  localparam logic [7:0] ALLRED = 8'h25;

  // ---------------- reference model (rule level) ----------------
  logic [7:0] m_q;
  int m_prev[2];
  int m_dwell[2];
  int m_mode;    // 0 arm, 1 monitor, 2 fault
  int m_code;
  int m_head;

  // 0 dark, 1 red, 2 yellow, 3 green, 4 several lit
  function automatic int lamp_of(input bit g, input bit y, input bit r);
    int n;
    n = int'(g) + int'(y) + int'(r);
    if (n > 1) return 4;
    if (g) return 3;
    if (y) return 2;
    if (r) return 1;
    return 0;
  endfunction

  function automatic bit legal(input int a, input int b);
    int from_t[5];
    int to_t[5];
    from_t = '{1, 3, 2, 1, 0};
    to_t   = '{3, 2, 1, 0, 1};
    for (int i = 0; i < 5; i++) if (from_t[i] == a && to_t[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q = 8'h00;
    m_prev = '{0, 0};
    m_dwell = '{0, 0};
    m_mode = 0;
    m_code = 0;
    m_head = 0;
  endtask

  task automatic model_step(input logic [7:0] now, input bit clr_now);
    bit viol[7][3];
    int v[2];
    int nd[2];
    bit gh[2], yh[2], rh[2];
    bit gw, rw, go0, go1;
    int bc, bh;
    gh[0] = m_q[7]; yh[0] = m_q[6]; rh[0] = m_q[5];
    gh[1] = m_q[4]; yh[1] = m_q[3]; rh[1] = m_q[2];
    gw = m_q[1]; rw = m_q[0];
    for (int c = 0; c < 7; c++) for (int h = 0; h < 3; h++) viol[c][h] = 1'b0;
    for (int h = 0; h < 2; h++) begin
      v[h]  = lamp_of(gh[h], yh[h], rh[h]);
      nd[h] = (v[h] == m_prev[h]) ? m_dwell[h] + 1 : 1;
    end
    go0 = gh[0] | yh[0];
    go1 = gh[1] | yh[1];
    if (go0 && (go1 || gw)) viol[1][0] = 1'b1;
    if (go1 && gw)          viol[1][1] = 1'b1;
    for (int h = 0; h < 2; h++) if (v[h] == 4) viol[2][h] = 1'b1;
    if (gw && rw) viol[2][2] = 1'b1;
    if (m_mode == 1) begin
      for (int h = 0; h < 2; h++) begin
        if (v[h] != m_prev[h]) begin
          if (!legal(m_prev[h], v[h]))              viol[3][h] = 1'b1;
          if (m_prev[h] == 3 && m_dwell[h] < 4)      viol[4][h] = 1'b1;
          if (m_prev[h] == 2 && m_dwell[h] < 2)      viol[5][h] = 1'b1;
        end
        if (v[h] == 0 && nd[h] > 4) viol[6][h] = 1'b1;
      end
    end
    bc = 0; bh = 0;
    for (int c = 1; c < 7; c++)
      for (int h = 0; h < 3; h++)
        if (viol[c][h] && bc == 0) begin bc = c; bh = h; end
    case (m_mode)
      0: begin
        if (bc != 0) begin m_mode = 2; m_code = bc; m_head = bh; end
        else if (rh[0] && rh[1] && rw) m_mode = 1;
      end
      1: if (bc != 0) begin m_mode = 2; m_code = bc; m_head = bh; end
      default: if (clr_now) begin m_mode = 0; m_code = 0; m_head = 0; end
    endcase
    for (int h = 0; h < 2; h++) begin
      m_prev[h]  = v[h];
      m_dwell[h] = nd[h];
    end
    m_q = now;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string name);
    int got, exp;
    got = {fault, fault_code, fault_head, flash_req, armed};
    exp = {m_mode == 2, 3'(m_code), 2'(m_head), m_mode == 2, m_mode == 1};
    chk(name, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input logic [7:0] l, input bit c, input string name);
    lamps = l;
    clr   = c;
    @(posedge CLK);
    model_step(l, c);
    #1;
    chk_model(name);
  endtask

  task automatic do_reset();
    lamps = 8'h00;
    clr   = 1'b0;
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic arm();
    cycle(ALLRED, 1'b0, "arm0");
    cycle(ALLRED, 1'b0, "arm1");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] l;
    bit         c;
    bit         f;
    int         code;
    int         head;
    bit         armed;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] legal_q[$];

  task automatic push_phase(input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) legal_q.push_back(l);
  endtask

  initial begin
    tbl[0]  = '{8'h25, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{8'h25, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[2]  = '{8'h91, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[3]  = '{8'h25, 1'b0, 1'b1, 1, 0, 1'b0};
    tbl[4]  = '{8'h65, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{8'h25, 1'b0, 1'b1, 2, 0, 1'b0};
    tbl[6]  = '{8'h25, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[7]  = '{8'h25, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[8]  = '{8'h27, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[9]  = '{8'h25, 1'b0, 1'b1, 2, 2, 1'b0};
    tbl[10] = '{8'h91, 1'b0, 1'b1, 2, 2, 1'b0};
    tbl[11] = '{8'h25, 1'b0, 1'b1, 2, 2, 1'b0};

    push_phase(8'h25, 2); push_phase(8'h85, 6); push_phase(8'h45, 4);
    push_phase(8'h25, 2); push_phase(8'h31, 6); push_phase(8'h29, 2);
    push_phase(8'h25, 2); push_phase(8'h26, 4);
    push_phase(8'h24, 1); push_phase(8'h26, 1); push_phase(8'h24, 1); push_phase(8'h26, 1);

    RST_N = 1'b1;
    lamps = 8'h00;
    clr   = 1'b0;

    // reset values
    do_reset();
    chk("reset_fault", fault, 0);
    chk("reset_code", fault_code, 0);
    chk("reset_head", fault_head, 0);
    chk("reset_flash", flash_req, 0);
    chk("reset_armed", armed, 0);

    // table vectors
    for (int i = 0; i < 12; i++) begin
      lamps = tbl[i].l;
      clr   = tbl[i].c;
      @(posedge CLK);
      model_step(tbl[i].l, tbl[i].c);
      #1;
      chk($sformatf("tbl%0d_fault", i), fault, int'(tbl[i].f));
      chk($sformatf("tbl%0d_code", i), fault_code, tbl[i].code);
      chk($sformatf("tbl%0d_head", i), fault_head, tbl[i].head);
      chk($sformatf("tbl%0d_armed", i), armed, int'(tbl[i].armed));
    end

    // legal controller cycle
    do_reset();
    for (int i = 0; i < 300; i++) cycle(legal_q[i % legal_q.size()], 1'b0, "legal");
    chk("legal_fault", fault, 0);
    chk("legal_armed", armed, 1);

    // A and B green together
    do_reset(); arm();
    cycle(8'h91, 1'b0, "conf0");
    chk("conf_early", fault, 0);
    cycle(ALLRED, 1'b0, "conf1");
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    chk("conf_head", fault_head, 0);
    chk("conf_flash", flash_req, 1);
    cycle(ALLRED, 1'b1, "clr");
    chk("clr_fault", fault, 0);
    chk("clr_armed", armed, 0);

    // short green on A
    do_reset(); arm();
    cycle(8'h85, 1'b0, "sg"); cycle(8'h85, 1'b0, "sg");
    cycle(8'h45, 1'b0, "sg"); cycle(8'h45, 1'b0, "sg");
    chk("sg_code", fault_code, 4);
    chk("sg_head", fault_head, 0);

    // short yellow on B
    do_reset(); arm();
    for (int i = 0; i < 4; i++) cycle(8'h31, 1'b0, "sy");
    cycle(8'h29, 1'b0, "sy");
    cycle(ALLRED, 1'b0, "sy"); cycle(ALLRED, 1'b0, "sy");
    chk("sy_code", fault_code, 5);
    chk("sy_head", fault_head, 1);

    // green straight to red on A
    do_reset(); arm();
    for (int i = 0; i < 5; i++) cycle(8'h85, 1'b0, "seq");
    cycle(ALLRED, 1'b0, "seq"); cycle(ALLRED, 1'b0, "seq");
    chk("seq_code", fault_code, 3);
    chk("seq_head", fault_head, 0);

    // Ya&Ra while still in ARM
    do_reset();
    cycle(8'h65, 1'b0, "arm_multi"); cycle(8'h65, 1'b0, "arm_multi");
    chk("arm_multi_code", fault_code, 2);
    chk("arm_multi_fault", fault, 1);

    // all dark in MONITOR
    do_reset(); arm();
    for (int j = 1; j <= 6; j++) begin
      cycle(8'h00, 1'b0, "dark");
      if (j == 5) chk("dark_early", fault, 0);
    end
    chk("dark_fault", fault, 1);
    chk("dark_code", fault_code, 6);
    chk("dark_head", fault_head, 0);

    // async reset while faulted
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("async_rst", {fault, fault_code, fault_head, flash_req, armed}, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // mutated legal cycle with random clears
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] l;
      bit c;
      l = legal_q[i % legal_q.size()];
      if ($urandom_range(0, 24) == 0) l = l ^ (8'h01 << $urandom_range(0, 7));
      c = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cycle(l, c, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
